prod_accum: RTL and testbench

PROD_ACCUM -- requirements
Module: prod_accum

---
 rtl/prod_accum.sv | 132 +++++++++++++
 tb/tb_prod_accum.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prod_accum.sv
// Product accumulator: sums N_TERMS unsigned products per group behind a valid/ready handshake.
// Define PROD_ACCUM_SAT_EN to clamp the sum on overflow instead of wrapping.
module prod_accum #(
   parameter int BITS    = 4,
   parameter int N_TERMS = 4,
   parameter int ACC_W   = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2*BITS-1:0]   product_i,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ACC_W-1:0]    sum_o,
   output logic [7:0]          cnt_o,
   output logic                ovf_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [7:0] LP_TERMS = 8'(N_TERMS);

   state_t            r_state;
   state_t            w_nextState;
   logic [ACC_W-1:0]  r_sum;
   logic [7:0]        r_cnt;
   logic              r_ovf;

   logic              w_accept;
   logic              w_lastTerm;
   logic              w_release;
   logic [ACC_W-1:0]  w_base;
   logic [ACC_W:0]    w_prodExt;
   logic [ACC_W:0]    w_total;
   logic              w_addOvf;
   logic [ACC_W-1:0]  w_sumNext;
   logic [7:0]        w_cntNext;

   assign w_accept  = in_valid & in_ready;
   assign w_release = (r_state == DONE) & out_ready;

   // A group starts from zero in IDLE; the extra top bit of the adder catches overflow.
   assign w_base     = (r_state == IDLE) ? '0 : r_sum;
   assign w_prodExt  = {{(ACC_W + 1 - 2*BITS){1'b0}}, product_i};
   assign w_total    = {1'b0, w_base} + w_prodExt;
   assign w_addOvf   = w_total[ACC_W];
   assign w_cntNext  = (r_state == IDLE) ? 8'd1 : r_cnt + 8'd1;
   assign w_lastTerm = (w_cntNext == LP_TERMS);

`ifdef PROD_ACCUM_SAT_EN
   assign w_sumNext = (w_addOvf | r_ovf) ? {ACC_W{1'b1}} : w_total[ACC_W-1:0];
`else
   assign w_sumNext = w_total[ACC_W-1:0];
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // clr wins over both a product acceptance and the result handshake.
   always_comb begin
      w_nextState = r_state;
      if (clr) begin
         w_nextState = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  w_nextState = w_lastTerm ? DONE : ACC;
               end
            end
            ACC: begin
               if (w_accept && w_lastTerm) begin
                  w_nextState = DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  w_nextState = IDLE;
               end
            end
            default: w_nextState = IDLE;
         endcase
      end
   end

   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      case (r_state)
         DONE: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sum <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (clr || w_release) begin
         r_sum <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_sum <= w_sumNext;
         r_cnt <= w_cntNext;
         r_ovf <= r_ovf | w_addOvf;
      end
   end

   assign sum_o = r_sum;
   assign cnt_o = r_cnt;
   assign ovf_o = r_ovf;

endmodule

// File: tb/tb_prod_accum.sv
// Testbench for prod_accum: a default instance (4 terms) and an 8-term instance,
// checked against a plain-arithmetic model of each group's sum and overflow flag.
module tb_prod_accum;

   localparam int ACC_MAX = (1 << 10) - 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       clr;

   logic       aInValid, aInReady, aOutValid, aOutReady, aOvf;
   logic [7:0] aProd, aCnt;
   logic [9:0] aSum;

   logic       bInValid, bInReady, bOutValid, bOutReady, bOvf;
   logic [7:0] bProd, bCnt;
   logic [9:0] bSum;

   int compareCount = 0;
   int failCount    = 0;

   prod_accum dutA (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (aInValid),
      .in_ready  (aInReady),
      .product_i (aProd),
      .out_valid (aOutValid),
      .out_ready (aOutReady),
      .sum_o     (aSum),
      .cnt_o     (aCnt),
      .ovf_o     (aOvf)
   );

   prod_accum #(.BITS(4), .N_TERMS(8), .ACC_W(10)) dutB (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_valid  (bInValid),
      .in_ready  (bInReady),
      .product_i (bProd),
      .out_valid (bOutValid),
      .out_ready (bOutReady),
      .sum_o     (bSum),
      .cnt_o     (bCnt),
      .ovf_o     (bOvf)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge so registered outputs have settled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Reference: the group result is just the arithmetic total, wrapped or clamped.
   function automatic void refModel(input int n, input int prods[8], output int expSum, output int expOvf);
      int total;
      total = 0;
      for (int i = 0; i < n; i++) total += prods[i];
      expOvf = (total > ACC_MAX) ? 1 : 0;
`ifdef PROD_ACCUM_SAT_EN
      expSum = (expOvf == 1) ? ACC_MAX : total;
`else
      expSum = total % (ACC_MAX + 1);
`endif
   endfunction

   task automatic driveIn(input bit big, input logic valid, input logic [7:0] prod);
      if (big) begin
         bInValid = valid;
         bProd    = prod;
      end else begin
         aInValid = valid;
         aProd    = prod;
      end
   endtask

   // Feeds one group (optionally with random bubbles) and checks the result appears at once.
   task automatic applyStimulus(input bit big, input int n, input int prods[8], input bit bubbles, input string tag);
      int accepted;
      int budget;
      int expSum;
      int expOvf;
      accepted = 0;
      budget   = 0;
      while (accepted < n && budget < 200) begin
         if (bubbles && $urandom_range(0, 2) == 0) begin
            driveIn(big, 1'b0, 8'($urandom_range(0, 255)));
            tick();
         end else begin
            driveIn(big, 1'b1, 8'(prods[accepted]));
            tick();
            accepted++;
         end
         budget++;
      end
      driveIn(big, 1'b0, 8'd0);
      checkOutput({tag, " accepted"}, accepted, n);
      refModel(n, prods, expSum, expOvf);
      checkOutput({tag, " out_valid"}, big ? bOutValid : aOutValid, 1);
      checkOutput({tag, " sum"},       big ? bSum : aSum, expSum);
      checkOutput({tag, " cnt"},       big ? bCnt : aCnt, n);
      checkOutput({tag, " ovf"},       big ? bOvf : aOvf, expOvf);
   endtask

   // Holds the result under back-pressure, checking stability, then completes the handshake.
   task automatic releaseResult(input bit big, input int hold, input int n, input int prods[8], input string tag);
      int expSum;
      int expOvf;
      refModel(n, prods, expSum, expOvf);
      if (big) bOutReady = 1'b0; else aOutReady = 1'b0;
      for (int i = 0; i < hold; i++) begin
         tick();
         checkOutput({tag, " hold out_valid"}, big ? bOutValid : aOutValid, 1);
         checkOutput({tag, " hold in_ready"},  big ? bInReady : aInReady, 0);
         checkOutput({tag, " hold sum"},       big ? bSum : aSum, expSum);
         checkOutput({tag, " hold cnt"},       big ? bCnt : aCnt, n);
         checkOutput({tag, " hold ovf"},       big ? bOvf : aOvf, expOvf);
      end
      if (big) bOutReady = 1'b1; else aOutReady = 1'b1;
      tick();
      if (big) bOutReady = 1'b0; else aOutReady = 1'b0;
      checkOutput({tag, " idle out_valid"}, big ? bOutValid : aOutValid, 0);
      checkOutput({tag, " idle in_ready"},  big ? bInReady : aInReady, 1);
      checkOutput({tag, " idle sum"},       big ? bSum : aSum, 0);
      checkOutput({tag, " idle cnt"},       big ? bCnt : aCnt, 0);
      checkOutput({tag, " idle ovf"},       big ? bOvf : aOvf, 0);
   endtask

   initial begin
      int p[8];
      int nb;

      rst = 1'b1;
      clr = 1'b0;
      aInValid = 1'b0; aProd = '0; aOutReady = 1'b0;
      bInValid = 1'b0; bProd = '0; bOutReady = 1'b0;

      // Reset values while rst is held.
      #2;
      checkOutput("reset sum", aSum, 0);
      checkOutput("reset cnt", aCnt, 0);
      checkOutput("reset ovf", aOvf, 0);
      checkOutput("reset out_valid", aOutValid, 0);
      tick();
      tick();
      rst = 1'b0;
      checkOutput("post-reset in_ready", aInReady, 1);

      // Four products of 225 back to back; result visible the cycle after the 4th acceptance.
      aInValid = 1'b1;
      aProd    = 8'd225;
      tick();
      checkOutput("run sum after 1", aSum, 225);
      checkOutput("run cnt after 1", aCnt, 1);
      tick();
      tick();
      checkOutput("out_valid before 4th", aOutValid, 0);
      checkOutput("run sum after 3", aSum, 675);
      tick();
      checkOutput("default out_valid", aOutValid, 1);
      checkOutput("default sum", aSum, 900);
      checkOutput("default cnt", aCnt, 4);
      checkOutput("default ovf", aOvf, 0);
      checkOutput("default in_ready", aInReady, 0);
      // in_valid stays high: nothing may be accepted during DONE or on the release edge.
      p = '{225, 225, 225, 225, 0, 0, 0, 0};
      releaseResult(1'b0, 5, 4, p, "backpressure");
      aInValid = 1'b0;

      // Bubbles between products.
      p = '{3, 0, 7, 5, 0, 0, 0, 0};
      for (int i = 0; i < 4; i++) begin
         aInValid = 1'b1;
         aProd    = 8'(p[i]);
         tick();
         checkOutput("bubble cnt", aCnt, i + 1);
         aInValid = 1'b0;
         aProd    = 8'($urandom_range(0, 255));
         tick();
         checkOutput("bubble cnt held", aCnt, i + 1);
      end
      checkOutput("bubble out_valid", aOutValid, 1);
      checkOutput("bubble sum", aSum, 15);
      checkOutput("bubble cnt", aCnt, 4);
      releaseResult(1'b0, 1, 4, p, "bubble");

      // Synchronous abort after two products, overriding a simultaneous acceptance.
      aInValid = 1'b1;
      aProd = 8'd10;
      tick();
      aProd = 8'd20;
      tick();
      checkOutput("abort partial sum", aSum, 30);
      clr   = 1'b1;
      aProd = 8'd30;
      tick();
      clr = 1'b0;
      checkOutput("clr sum", aSum, 0);
      checkOutput("clr cnt", aCnt, 0);
      checkOutput("clr out_valid", aOutValid, 0);
      checkOutput("clr in_ready", aInReady, 1);

      // Asynchronous reset in the middle of a group.
      aProd = 8'd5;
      tick();
      aProd = 8'd6;
      tick();
      checkOutput("pre-rst cnt", aCnt, 2);
      aProd = 8'd7;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async rst sum", aSum, 0);
      checkOutput("async rst cnt", aCnt, 0);
      tick();
      rst = 1'b0;
      aInValid = 1'b0;
      checkOutput("rst held sum", aSum, 0);
      tick();
      checkOutput("after rst out_valid", aOutValid, 0);
      checkOutput("after rst cnt", aCnt, 0);

      p = '{1, 2, 3, 4, 0, 0, 0, 0};
      applyStimulus(1'b0, 4, p, 1'b0, "post-abort group");

      // clr while a result is pending discards it.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checkOutput("clr in DONE out_valid", aOutValid, 0);
      checkOutput("clr in DONE sum", aSum, 0);
      checkOutput("clr in DONE in_ready", aInReady, 1);

      // Eight products of 225 overflow the 10-bit accumulator.
      p = '{225, 225, 225, 225, 225, 225, 225, 225};
      applyStimulus(1'b1, 8, p, 1'b0, "n8 overflow");
      releaseResult(1'b1, 2, 8, p, "n8 overflow");

      // Randomized groups on both instances.
      for (int g = 0; g < 6; g++) begin
         for (int i = 0; i < 8; i++) p[i] = (i < 4) ? int'($urandom_range(0, 255)) : 0;
         applyStimulus(1'b0, 4, p, 1'b1, "rand n4");
         releaseResult(1'b0, int'($urandom_range(0, 3)), 4, p, "rand n4");
      end
      for (int g = 0; g < 6; g++) begin
         for (int i = 0; i < 8; i++) p[i] = int'($urandom_range(0, 255));
         nb = int'($urandom_range(0, 1));
         applyStimulus(1'b1, 8, p, nb[0], "rand n8");
         releaseResult(1'b1, int'($urandom_range(0, 3)), 8, p, "rand n8");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
